// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two data-memory requesters, the arbiter and data_memory.
// The slave modport is the arbiter's view; master is the requester/memory-model view.
`ifndef WORD
`define WORD 64
`endif

interface dmem_arbiter_if #(
    parameter int unsigned DW = `WORD
);
    logic          p0_req;
    logic          p0_we;
    logic [DW-1:0] p0_addr;
    logic [DW-1:0] p0_wdata;
    logic          p0_ready;
    logic [DW-1:0] p0_rdata;
    logic          p0_stall;

    logic          p1_req;
    logic          p1_we;
    logic [DW-1:0] p1_addr;
    logic [DW-1:0] p1_wdata;
    logic          p1_ready;
    logic [DW-1:0] p1_rdata;

    logic          mem_read;
    logic          mem_write;
    logic [DW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  p0_req, p0_we, p0_addr, p0_wdata,
        input  p1_req, p1_we, p1_addr, p1_wdata,
        input  mem_rdata,
        output p0_ready, p0_rdata, p0_stall,
        output p1_ready, p1_rdata,
        output mem_read, mem_write, mem_addr, mem_wdata
    );

    modport master (
        output p0_req, p0_we, p0_addr, p0_wdata,
        output p1_req, p1_we, p1_addr, p1_wdata,
        output mem_rdata,
        input  p0_ready, p0_rdata, p0_stall,
        input  p1_ready, p1_rdata,
        input  mem_read, mem_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer for the single-port data memory (MEM stage = port 0, loader = port 1).
// Define MEM_ARB_RR_EN for round-robin contention handling; otherwise port 0 has fixed priority.
`ifndef WORD
`define WORD 64
`endif

module dmem_arbiter #(
    parameter int unsigned DW  = `WORD,
    parameter int unsigned LAT = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    dmem_arbiter_if.slave  bus
);
    localparam int unsigned CW = 3;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

    state_e        state_q, state_d;
    logic          owner_q, owner_d;
    logic          we_q, we_d;
    logic [DW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rdata0_q, rdata0_d;
    logic [DW-1:0] rdata1_q, rdata1_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rdy0_q, rdy0_d;
    logic          rdy1_q, rdy1_d;
    logic          grant_c;

`ifdef MEM_ARB_RR_EN
    // last_q holds the port that won the most recent contended arbitration
    logic          last_q, last_d;
    logic          both_c;

    always_comb begin
        both_c  = bus.p0_req & bus.p1_req;
        grant_c = both_c ? ~last_q : ~bus.p0_req;
    end
`else
    always_comb begin
        grant_c = ~bus.p0_req;
    end
`endif

    // Next-state and capture logic
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        cnt_d    = cnt_q;
        rdy0_d   = 1'b0;
        rdy1_d   = 1'b0;
`ifdef MEM_ARB_RR_EN
        last_d   = last_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.p0_req | bus.p1_req) begin
                    owner_d = grant_c;
                    we_d    = grant_c ? bus.p1_we    : bus.p0_we;
                    addr_d  = grant_c ? bus.p1_addr  : bus.p0_addr;
                    wdata_d = grant_c ? bus.p1_wdata : bus.p0_wdata;
                    cnt_d   = we_d ? '0 : CW'(LAT - 1);
                    state_d = BUSY;
`ifdef MEM_ARB_RR_EN
                    if (both_c) begin
                        last_d = grant_c;
                    end
`endif
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    if (!we_q) begin
                        if (owner_q) rdata1_d = bus.mem_rdata;
                        else         rdata0_d = bus.mem_rdata;
                    end
                    rdy0_d  = ~owner_q;
                    rdy1_d  = owner_q;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            owner_q  <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
            cnt_q    <= '0;
            rdy0_q   <= 1'b0;
            rdy1_q   <= 1'b0;
`ifdef MEM_ARB_RR_EN
            last_q   <= 1'b1;
`endif
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
            cnt_q    <= cnt_d;
            rdy0_q   <= rdy0_d;
            rdy1_q   <= rdy1_d;
`ifdef MEM_ARB_RR_EN
            last_q   <= last_d;
`endif
        end
    end

    // Strobes decode straight from state so reset kills an in-flight access immediately
    assign bus.mem_read  = (state_q == BUSY) & ~we_q;
    assign bus.mem_write = (state_q == BUSY) & we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;

    assign bus.p0_ready  = rdy0_q;
    assign bus.p1_ready  = rdy1_q;
    assign bus.p0_rdata  = rdata0_q;
    assign bus.p1_rdata  = rdata1_q;
    assign bus.p0_stall  = bus.p0_req & ~rdy0_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter (LAT=2): reset abort, load/store timing,
// address capture and two-port contention in either arbitration build.
module tb_dmem_arbiter;
    localparam int unsigned DW  = 64;
    localparam int unsigned LAT = 2;
`ifdef MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.DW(DW)) bus ();
    dmem_arbiter #(.DW(DW), .LAT(LAT)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int            total  = 0;
    int            bad    = 0;
    int            wr_cnt = 0;
    logic [DW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;

    // Memory model: fixed read contents, write observer
    always_comb begin
        case (bus.mem_addr)
            64'h20:  bus.mem_rdata = 64'hDEADBEEF;
            64'h28:  bus.mem_rdata = 64'hCAFE;
            64'h08:  bus.mem_rdata = 64'h1111;
            64'h18:  bus.mem_rdata = 64'h3333;
            default: bus.mem_rdata = '0;
        endcase
    end

    always @(posedge clk) begin
        if (bus.mem_write) begin
            wr_cnt  <= wr_cnt + 1;
            wr_addr <= bus.mem_addr;
            wr_data <= bus.mem_wdata;
        end
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive0(input logic req, input logic we, input logic [DW-1:0] a, input logic [DW-1:0] d);
        bus.p0_req = req; bus.p0_we = we; bus.p0_addr = a; bus.p0_wdata = d;
    endtask

    task automatic drive1(input logic req, input logic we, input logic [DW-1:0] a, input logic [DW-1:0] d);
        bus.p1_req = req; bus.p1_we = we; bus.p1_addr = a; bus.p1_wdata = d;
    endtask

    task automatic edge_drive();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic exp0;
        drive0(1'b0, 1'b0, '0, '0);
        drive1(1'b0, 1'b0, '0, '0);

        // Reset values
        repeat (2) @(negedge clk);
        chk1("rst p0_ready", bus.p0_ready, 1'b0);
        chk1("rst p1_ready", bus.p1_ready, 1'b0);
        chk1("rst mem_read", bus.mem_read, 1'b0);
        chk1("rst mem_write", bus.mem_write, 1'b0);
        chkw("rst p0_rdata", bus.p0_rdata, '0);
        chkw("rst p1_rdata", bus.p1_rdata, '0);
        chkw("rst mem_addr", bus.mem_addr, '0);
        chkw("rst mem_wdata", bus.mem_wdata, '0);
        chk1("rst p0_stall", bus.p0_stall, 1'b0);
        rst_n = 1'b1;

        // Reset asserted during the BUSY cycle of a store
        edge_drive();
        drive0(1'b1, 1'b1, 64'h10, 64'hAB);
        @(negedge clk);
        chk1("A c0 stall", bus.p0_stall, 1'b1);
        chk1("A c0 mem_write", bus.mem_write, 1'b0);
        edge_drive();
        chk1("A c1 mem_write", bus.mem_write, 1'b1);
        chkw("A c1 mem_addr", bus.mem_addr, 64'h10);
        #1 rst_n = 1'b0;
        #1;
        chk1("A rst mem_write", bus.mem_write, 1'b0);
        chk1("A rst p0_ready", bus.p0_ready, 1'b0);
        bus.p0_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk1("A post p0_ready", bus.p0_ready, 1'b0);
        end
        chkw("A no write", DW'(wr_cnt), '0);

        // p0 load at 0x20, LAT=2
        edge_drive();
        drive0(1'b1, 1'b0, 64'h20, '0);
        @(negedge clk);
        chk1("B c0 mem_read", bus.mem_read, 1'b0);
        chk1("B c0 stall", bus.p0_stall, 1'b1);
        @(negedge clk);
        chk1("B c1 mem_read", bus.mem_read, 1'b1);
        chkw("B c1 mem_addr", bus.mem_addr, 64'h20);
        chk1("B c1 stall", bus.p0_stall, 1'b1);
        @(negedge clk);
        chk1("B c2 mem_read", bus.mem_read, 1'b1);
        chk1("B c2 p0_ready", bus.p0_ready, 1'b0);
        chk1("B c2 stall", bus.p0_stall, 1'b1);
        @(negedge clk);
        chk1("B c3 p0_ready", bus.p0_ready, 1'b1);
        chkw("B c3 p0_rdata", bus.p0_rdata, 64'hDEADBEEF);
        chk1("B c3 mem_read", bus.mem_read, 1'b0);
        chk1("B c3 stall", bus.p0_stall, 1'b0);
        edge_drive();
        bus.p0_req = 1'b0;
        @(negedge clk);
        chk1("B c4 p0_ready", bus.p0_ready, 1'b0);
        chkw("B c4 p0_rdata hold", bus.p0_rdata, 64'hDEADBEEF);

        // p1 store of 0x55 to 0x40
        edge_drive();
        drive1(1'b1, 1'b1, 64'h40, 64'h55);
        @(negedge clk);
        chk1("C c0 mem_write", bus.mem_write, 1'b0);
        @(negedge clk);
        chk1("C c1 mem_write", bus.mem_write, 1'b1);
        chk1("C c1 mem_read", bus.mem_read, 1'b0);
        chkw("C c1 mem_addr", bus.mem_addr, 64'h40);
        chkw("C c1 mem_wdata", bus.mem_wdata, 64'h55);
        chk1("C c1 p1_ready", bus.p1_ready, 1'b0);
        @(negedge clk);
        chk1("C c2 p1_ready", bus.p1_ready, 1'b1);
        chk1("C c2 p0_ready", bus.p0_ready, 1'b0);
        chk1("C c2 mem_write", bus.mem_write, 1'b0);
        edge_drive();
        bus.p1_req = 1'b0;
        @(negedge clk);
        chk1("C c3 p1_ready", bus.p1_ready, 1'b0);
        chkw("C wr count", DW'(wr_cnt), 64'd1);
        chkw("C wr addr", wr_addr, 64'h40);
        chkw("C wr data", wr_data, 64'h55);
        chkw("C p1_rdata untouched", bus.p1_rdata, '0);

        // Address change after capture is ignored
        edge_drive();
        drive0(1'b1, 1'b0, 64'h08, '0);
        edge_drive();
        bus.p0_addr = 64'h18;
        @(negedge clk);
        chkw("D c1 mem_addr", bus.mem_addr, 64'h08);
        @(negedge clk);
        chkw("D c2 mem_addr", bus.mem_addr, 64'h08);
        @(negedge clk);
        chk1("D c3 p0_ready", bus.p0_ready, 1'b1);
        chkw("D c3 p0_rdata", bus.p0_rdata, 64'h1111);
        edge_drive();
        bus.p0_req = 1'b0;
        @(negedge clk);

        // Both ports requesting continuously
        edge_drive();
        drive0(1'b1, 1'b0, 64'h20, '0);
        drive1(1'b1, 1'b0, 64'h28, '0);
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            chk1("E strobe exclusive", bus.mem_read & bus.mem_write, 1'b0);
            if ((c % 4) == 3) begin
                exp0 = RR ? (((c / 4) % 2) == 0) : 1'b1;
                chk1("E p0_ready", bus.p0_ready, exp0);
                chk1("E p1_ready", bus.p1_ready, ~exp0);
                chkw("E p0_rdata", bus.p0_rdata, 64'hDEADBEEF);
                if (!exp0) chkw("E p1_rdata", bus.p1_rdata, 64'hCAFE);
            end else begin
                chk1("E idle p0_ready", bus.p0_ready, 1'b0);
                chk1("E idle p1_ready", bus.p1_ready, 1'b0);
            end
        end
        edge_drive();
        bus.p0_req = 1'b0;
        bus.p1_req = 1'b0;
        @(negedge clk);
        chk1("E end p0_ready", bus.p0_ready, 1'b0);
`ifndef MEM_ARB_RR_EN
        chkw("E p1 starved rdata", bus.p1_rdata, '0);
`endif
        repeat (2) @(negedge clk);
        chk1("E quiet mem_read", bus.mem_read, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter and access sequencer for the single-port data memory. It shares `data_memory` between the pipeline MEM stage (port 0) and a loader/debug port (port 1). It captures each request, drives the memory's `mem_read`/`mem_write`/address/write-data for the required number of cycles, and returns a one-cycle completion pulse with registered read data. It sits between the MEM-stage logic and `data_memory`, and provides the stall signal the pipeline uses while the MEM stage waits.

## Interface
- `DW`, default `` `WORD`` (64): address and data width.
- `LAT`, default 1: memory read latency in cycles. Legal range 1..7.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `p0_req` in 1: MEM-stage request. Held, with its address and data, until `p0_ready`.
- `p0_we` in 1: 1 = store (STUR), 0 = load (LDUR).
- `p0_addr` in DW: byte address, from the ALU result.
- `p0_wdata` in DW: store data.
- `p0_ready` out 1: one-cycle completion pulse.
- `p0_rdata` out DW: load data, valid while `p0_ready` is high.
- `p0_stall` out 1: equals `p0_req & ~p0_ready`, combinational.
- `p1_req`, `p1_we`, `p1_addr`, `p1_wdata`, `p1_ready`, `p1_rdata`: same meanings as the port 0 signals, for the loader port.
- `mem_read` out 1: to `data_memory`.
- `mem_write` out 1: to `data_memory`.
- `mem_addr` out DW: to `data_memory`.
- `mem_wdata` out DW: to `data_memory`.
- `mem_rdata` in DW: from `data_memory`.

## Operation
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - If any request is high, select a winner and register `owner`, `we`, `addr`, `wdata`.
  - Load the cycle counter `cnt` with 0 for a write, or LAT-1 for a read.
  - Move to BUSY. With no request, stay in IDLE.
- BUSY:
  - Drive `mem_addr`/`mem_wdata` from the captured registers.
  - Assert `mem_write` (write) or `mem_read` (read).
  - When `cnt` reaches 0: for a read, latch `mem_rdata` into the owner's rdata register; then move to RESP.
  - Otherwise decrement `cnt` and stay in BUSY.
- RESP:
  - Assert `owner`'s ready for exactly one cycle; the memory strobes are low.
  - Return to IDLE.
- Arbitration with a single request: grant it.
- Arbitration with both requesting: select the winner per Configuration.
- Request inputs are sampled only in IDLE. Address or data changes after capture are ignored.
- Request dropped mid-transaction: the transaction still completes and ready is still pulsed. The requester must ignore the pulse.
- The non-owner port's ready stays 0. Its rdata register holds its previous value.
- Reset (asynchronous, any state):
  - State returns to IDLE; `mem_read`, `mem_write`, both ready signals and `cnt` go to 0.
  - Both rdata registers, `mem_addr` and `mem_wdata` go to 0.
  - The round-robin pointer is set so that port 0 wins first.
  - An in-flight write is aborted at once.
- `mem_read` and `mem_write` are never high together and are never high outside BUSY.

## Timing
- Store: request seen in IDLE at cycle 0. `mem_write` is high in cycle 1 and `ready` in cycle 2. Occupancy is 3 cycles.
- Load: `mem_read` is high in cycles 1..LAT, `ready`/`rdata` in cycle LAT+1. Occupancy is LAT+2 cycles.
- A requester drops `req` in the cycle after `ready`. IDLE therefore sees the new `req` value, so there is no double grant.
- Back-to-back transactions are separated by one IDLE cycle.
- All outputs except `p*_stall` and the pass-through `mem_*` fields are registered.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin. On contention, the port not granted last wins. The pointer updates only on contention grants.
- `MEM_ARB_RR_EN` undefined: fixed priority. Port 0 always wins on contention, and port 1 may starve under continuous MEM traffic. The pointer register is not built.

## Test plan
- Reset during BUSY write (LAT=1):
  - Stimulus: p0 store to 0x10; `rst_n` low in cycle 1.
  - Response: `mem_write` drops immediately; no `p0_ready`; state IDLE.
- p0 load at 0x20 with memory returning 0xDEADBEEF, LAT=2:
  - Response: `mem_read` high in cycles 1-2.
  - `p0_ready` is high only in cycle 3, with `p0_rdata`=0xDEADBEEF; `p0_stall` is high in cycles 0-2.
- p1 store of 0x55 to 0x40:
  - Response: `mem_write` in cycle 1 with `mem_addr`=0x40 and `mem_wdata`=0x55.
  - `p1_ready` in cycle 2; `p0_ready` stays 0.
- Both ports request continuously, `MEM_ARB_RR_EN` defined:
  - Response: grants alternate p0, p1, p0, p1. p0's rdata holds its value across p1's transactions.
- Same stimulus with `MEM_ARB_RR_EN` undefined:
  - Response: p0 wins every arbitration and `p1_ready` never pulses.
- p0 changes `p0_addr` from 0x8 to 0x18 in cycle 1 of a load:
  - Response: `mem_addr` stays 0x8 for the whole transaction.
